// File: rtl/ddr_judge_pkg.sv
// Shared definitions for the DDR hit-judgement engine: grade and state
// encodings plus the default lane count.
package ddr_judge_pkg;

    localparam int DEF_NUM_LANES = 4;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'b00,
        GRADE_GOOD    = 2'b01,
        GRADE_PERFECT = 2'b10,
        GRADE_STRAY   = 2'b11
    } grade_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_DONE  = 2'b10,
        ST_OVER  = 2'b11
    } judge_state_t;

endpackage

// File: rtl/ddr_judge_if.sv
// Arrow/button inputs and judgement outputs between the arrow shifter,
// the judge and the score/display logic.
interface ddr_judge_if #(
    parameter int NUM_LANES  = 4,
    parameter int COMBO_BITS = 14,
    parameter int LIVES_BITS = 3
);
    logic                  beat;
    logic [NUM_LANES-1:0]  arrow;
    logic [NUM_LANES-1:0]  btn;
    logic                  pause;
    logic                  restart;
    logic                  judge_valid;
    logic [1:0]            judge_grade;
    logic [COMBO_BITS-1:0] combo;
    logic [3:0]            multiplier;
    logic [LIVES_BITS-1:0] lives;
    logic                  game_over;

    modport master (
        output beat, arrow, btn, pause, restart,
        input  judge_valid, judge_grade, combo, multiplier, lives, game_over
    );

    modport slave (
        input  beat, arrow, btn, pause, restart,
        output judge_valid, judge_grade, combo, multiplier, lives, game_over
    );
endinterface

// File: rtl/ddr_judge_edge_detect.sv
// Registered rising-edge detector. The level is tracked every cycle; clear
// suppresses edges so presses that begin while frozen never fire later.
module ddr_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            rise    <= '0;
        end else begin
            level_q <= level;
            rise    <= clear ? '0 : (level & ~level_q);
        end
    end
endmodule

// File: rtl/ddr_judge.sv
// Multi-lane hit judge: grades chord presses against the beat window and
// keeps combo, multiplier and lives.
module ddr_judge
    import ddr_judge_pkg::*;
#(
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int PERFECT_WIN   = 4,
    parameter int GOOD_WIN      = 12,
    parameter int COMBO_BITS    = 14,
    parameter int COMBO_STEP    = 4,
    parameter int MAX_MULT      = 8,
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_BITS    = 3,
    parameter bit STRAY_PENALTY = 1'b1
) (
    input logic        clk,
    input logic        reset,
    ddr_judge_if.slave bus
);
    localparam int WIN_BITS = $clog2(GOOD_WIN + 1);
    localparam logic [WIN_BITS-1:0]   WIN_GOOD = WIN_BITS'(GOOD_WIN);
    localparam logic [WIN_BITS-1:0]   WIN_PERF = WIN_BITS'(PERFECT_WIN);
    localparam logic [LIVES_BITS-1:0] LIVES0   = LIVES_BITS'(LIVES_INIT);

    judge_state_t          state, state_nx;
    grade_t                grade, grade_nx;
    logic [WIN_BITS-1:0]   win_cnt, win_cnt_nx;
    logic [NUM_LANES-1:0]  mask, mask_nx, hit_acc, hit_acc_nx, edges, hits;
    logic [COMBO_BITS-1:0] combo, combo_nx, steps;
    logic [LIVES_BITS-1:0] lives, lives_nx;
    logic [3:0]            mult, mult_nx;
    logic                  judge, judge_nx, over, over_nx;

    ddr_edge_detect #(.WIDTH(NUM_LANES)) u_edge (
        .clk   (clk),
        .reset (reset),
        .clear (bus.pause),
        .level (bus.btn),
        .rise  (edges)
    );

    always_comb begin
        state_nx   = state;
        grade_nx   = grade;
        win_cnt_nx = win_cnt;
        mask_nx    = mask;
        hit_acc_nx = hit_acc;
        combo_nx   = combo;
        lives_nx   = lives;
        over_nx    = over;
        judge_nx   = 1'b0;
        hits       = hit_acc | (edges & mask);
        if (bus.restart) begin
            state_nx   = ST_IDLE;
            grade_nx   = GRADE_MISS;
            win_cnt_nx = '0;
            mask_nx    = '0;
            hit_acc_nx = '0;
            combo_nx   = '0;
            lives_nx   = LIVES0;
            over_nx    = 1'b0;
        end else if (!bus.pause && state != ST_OVER) begin
            if (state == ST_ARMED) begin
                win_cnt_nx = (win_cnt == WIN_GOOD) ? win_cnt : win_cnt + 1'b1;
                hit_acc_nx = hits;
                // stray beats completion; a beat only forces MISS if this cycle's edges can't finish the chord
                if ((edges & ~mask) != '0) begin
                    judge_nx = 1'b1;
                    grade_nx = GRADE_STRAY;
                    state_nx = ST_DONE;
                end else if (hits == mask) begin
                    judge_nx = 1'b1;
                    grade_nx = (win_cnt < WIN_PERF) ? GRADE_PERFECT : GRADE_GOOD;
                    state_nx = ST_DONE;
                end else if (win_cnt == WIN_GOOD || bus.beat) begin
                    judge_nx = 1'b1;
                    grade_nx = GRADE_MISS;
                    state_nx = ST_DONE;
                end
            end else if (STRAY_PENALTY && edges != '0) begin
                judge_nx = 1'b1;
                grade_nx = GRADE_STRAY;
            end
            if (bus.beat) begin
                state_nx   = (bus.arrow != '0) ? ST_ARMED : ST_IDLE;
                win_cnt_nx = '0;
                hit_acc_nx = '0;
                mask_nx    = bus.arrow;
            end
            if (judge_nx) begin
                if (grade_nx == GRADE_PERFECT || grade_nx == GRADE_GOOD) begin
                    combo_nx = (&combo) ? combo : combo + 1'b1;
                end else begin
                    combo_nx = '0;
                    lives_nx = (lives == '0) ? lives : lives - 1'b1;
                    if (lives_nx == '0) begin
                        over_nx  = 1'b1;
                        state_nx = ST_OVER;
                    end
                end
            end
        end
    end

    // multiplier is derived from the registered combo, hence one cycle behind it
    always_comb begin
        steps   = combo / COMBO_BITS'(COMBO_STEP);
        mult_nx = (steps >= COMBO_BITS'(MAX_MULT - 1)) ? 4'(MAX_MULT) : 4'(steps) + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            grade   <= GRADE_MISS;
            win_cnt <= '0;
            mask    <= '0;
            hit_acc <= '0;
            combo   <= '0;
            lives   <= LIVES0;
            over    <= 1'b0;
            judge   <= 1'b0;
            mult    <= 4'd1;
        end else begin
            state   <= state_nx;
            grade   <= grade_nx;
            win_cnt <= win_cnt_nx;
            mask    <= mask_nx;
            hit_acc <= hit_acc_nx;
            combo   <= combo_nx;
            lives   <= lives_nx;
            over    <= over_nx;
            judge   <= judge_nx;
            mult    <= bus.restart ? 4'd1 : mult_nx;
        end
    end

    assign bus.judge_valid = judge;
    assign bus.judge_grade = grade;
    assign bus.combo       = combo;
    assign bus.multiplier  = mult;
    assign bus.lives       = lives;
    assign bus.game_over   = over;
endmodule
